// File: rtl/gpu_pkg.sv
// Shared types and constants for the instruction ingress path.
package gpu_pkg;

    localparam int INST_W = 82;
    localparam int WORD_W = 32;
    localparam int BEATS  = 3;

    typedef logic [INST_W-1:0] inst_t;

    // Which host beat of the current instruction is expected next.
    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2
    } beat_t;

    // Beat sequence B0 -> B1 -> B2 -> B0.
    function automatic beat_t next_beat(input beat_t b);
        case (b)
            B0:      return B1;
            B1:      return B2;
            default: return B0;
        endcase
    endfunction

endpackage

// File: rtl/inst_sync_fifo.sv
// Show-ahead synchronous FIFO: storage, pointers, occupancy count and
// registered empty/full flags. Head entry is presented combinationally
// from registered state, forced to zero while empty.
module inst_sync_fifo #(
    parameter int W     = 82,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          empty_q,  empty_d;
    logic          full_q,   full_d;

    logic          push_ok;
    logic          pop_ok;

    // A full FIFO never accepts a write, even when a pop frees a slot in
    // the same cycle; a pop needs a stored entry.
    assign push_ok = push & ~full_q;
    assign pop_ok  = pop & ~empty_q;

    // Next-state pointers, count and flags derived from next count.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == CW'(0));
        full_d  = (count_d == CW'(DEPTH));
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Storage write; contents are not reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = empty_q ? '0 : mem[rd_ptr_q];
    assign empty   = empty_q;
    assign full    = full_q;
    assign count   = count_q;

endmodule

// File: rtl/inst_ingress_fifo.sv
// Instruction ingress: packs three host beats into one instruction,
// checks framing against host_last, and buffers complete instructions
// in a show-ahead FIFO read by the controller.
module inst_ingress_fifo #(
    parameter int WORD_W = gpu_pkg::WORD_W,
    parameter int INST_W = gpu_pkg::INST_W,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     host_valid,
    input  logic [WORD_W-1:0]        host_data,
    input  logic                     host_last,
    output logic                     host_ready,
    input  logic                     read_en,
    output logic [INST_W-1:0]        fifo_data,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_err,
    input  logic                     clear_err
);

    import gpu_pkg::*;

    // Bits of the final beat that land in the instruction; the rest of
    // that beat is dropped.
    localparam int TOP_W = INST_W - 2 * WORD_W;

    beat_t                  beat_q, beat_d;
    logic [2*WORD_W-1:0]    lo_q,   lo_d;
    logic                   err_q,  err_d;

    logic                   accept;
    logic                   push;
    logic                   frame_set;
    logic                   full_w;
    logic [INST_W-1:0]      packed_inst;
    logic                   unused_hi_bits;

    // Only the closing beat can be stalled, and only by a full FIFO.
    assign host_ready = (beat_q != B2) | ~full_w;
    assign accept     = host_valid & host_ready;

    // Assembler: collect beats, detect framing errors, decide on push.
    always_comb begin
        beat_d    = beat_q;
        lo_d      = lo_q;
        push      = 1'b0;
        frame_set = 1'b0;
        if (accept) begin
            case (beat_q)
                B0: begin
                    lo_d[WORD_W-1:0] = host_data;
                    frame_set        = host_last;
                    beat_d           = host_last ? B0 : next_beat(beat_q);
                end
                B1: begin
                    lo_d[2*WORD_W-1:WORD_W] = host_data;
                    frame_set               = host_last;
                    beat_d                  = host_last ? B0 : next_beat(beat_q);
                end
                default: begin
                    push      = host_last;
                    frame_set = ~host_last;
                    beat_d    = B0;
                end
            endcase
        end
    end

    // Sticky framing error; a new error wins over a clear in the same cycle.
    always_comb begin
        err_d = err_q;
        if (frame_set) begin
            err_d = 1'b1;
        end else if (clear_err) begin
            err_d = 1'b0;
        end
    end

    // Assembler state and error flag registers.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            beat_q <= B0;
            lo_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            beat_q <= beat_d;
            lo_q   <= lo_d;
            err_q  <= err_d;
        end
    end

    assign packed_inst    = {host_data[TOP_W-1:0], lo_q};
    assign unused_hi_bits = ^host_data[WORD_W-1:TOP_W];

    inst_sync_fifo #(
        .W     (INST_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .push    (push),
        .wr_data (packed_inst),
        .pop     (read_en),
        .rd_data (fifo_data),
        .empty   (fifo_empty),
        .full    (full_w),
        .count   (count)
    );

    assign fifo_full = full_w;
    assign frame_err = err_q;

endmodule

// File: tb/tb_inst_ingress_fifo.sv
// Testbench for inst_ingress_fifo: directed steps plus random traffic,
// checked each cycle against a queue-based reference model.
module tb_inst_ingress_fifo;

    import gpu_pkg::*;

    localparam int DEPTH = 8;

    logic        clk;
    logic        n_rst;
    logic        host_valid;
    logic [31:0] host_data;
    logic        host_last;
    logic        host_ready;
    logic        read_en;
    logic [81:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_full;
    logic [3:0]  count;
    logic        frame_err;
    logic        clear_err;

    inst_ingress_fifo #(
        .WORD_W (32),
        .INST_W (82),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .host_valid (host_valid),
        .host_data  (host_data),
        .host_last  (host_last),
        .host_ready (host_ready),
        .read_en    (read_en),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .count      (count),
        .frame_err  (frame_err),
        .clear_err  (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: beat index, partial words, stored instructions, error flag.
    int          mbeat;
    logic [63:0] mlo;
    inst_t       mq[$];
    bit          merr;

    int total;
    int bad;
    bit tb_acc;

    task automatic chk(input string tag, input logic [81:0] obs, input logic [81:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        mbeat = 0;
        mlo   = '0;
        merr  = 1'b0;
    endtask

    task automatic check_outputs();
        inst_t head;
        head = '0;
        if (mq.size() > 0) head = mq[0];
        chk("empty", 82'(fifo_empty), 82'(mq.size() == 0));
        chk("full",  82'(fifo_full),  82'(mq.size() == DEPTH));
        chk("count", 82'(count),      82'(mq.size()));
        chk("data",  fifo_data,       head);
        chk("frame_err", 82'(frame_err), 82'(merr));
        chk("ready", 82'(host_ready), 82'((mbeat != 2) || (mq.size() < DEPTH)));
    endtask

    // One clock: predict from pre-edge inputs and model state, then check.
    task automatic step(output bit acc);
        bit pop_m;
        bit set_m;
        acc   = host_valid && ((mbeat != 2) || (mq.size() < DEPTH));
        pop_m = read_en && (mq.size() > 0);
        set_m = 1'b0;
        @(posedge clk);
        #1;
        if (pop_m) void'(mq.pop_front());
        if (acc) begin
            if (mbeat == 2) begin
                if (host_last) mq.push_back({host_data[17:0], mlo});
                else set_m = 1'b1;
                mbeat = 0;
            end else if (host_last) begin
                set_m = 1'b1;
                mbeat = 0;
            end else begin
                if (mbeat == 0) mlo[31:0] = host_data;
                else mlo[63:32] = host_data;
                mbeat++;
            end
        end
        if (set_m) merr = 1'b1;
        else if (clear_err) merr = 1'b0;
        check_outputs();
    endtask

    // Offer one beat until accepted (bounded); read_en only on the first cycle.
    task automatic send_beat(input logic [31:0] d, input bit last, input bit rd);
        bit acc;
        int n;
        host_valid = 1'b1;
        host_data  = d;
        host_last  = last;
        read_en    = rd;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 64) begin
            step(acc);
            read_en = 1'b0;
            n++;
        end
        chk("beat_accepted", 82'(acc), 82'(1));
        host_valid = 1'b0;
        host_last  = 1'b0;
    endtask

    task automatic send_inst(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input bit rd_last);
        send_beat(w0, 1'b0, 1'b0);
        send_beat(w1, 1'b0, 1'b0);
        send_beat(w2, 1'b1, rd_last);
    endtask

    task automatic pops(input int n);
        bit acc;
        read_en = 1'b1;
        for (int i = 0; i < n; i++) step(acc);
        read_en = 1'b0;
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        bit acc;
        host_valid = 1'b0;
        host_last  = 1'b0;
        read_en    = 1'b0;
        clear_err  = 1'b0;
        #2;
        n_rst = 1'b1;
        #1;
        model_clear();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        n_rst = 1'b0;
        step(acc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        total      = 0;
        bad        = 0;
        n_rst      = 1'b1;
        host_valid = 1'b0;
        host_data  = '0;
        host_last  = 1'b0;
        read_en    = 1'b0;
        clear_err  = 1'b0;
        model_clear();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        n_rst = 1'b0;
        step(tb_acc);

        // Single instruction, visible the cycle after the closing beat
        send_inst(32'hDEADBEEF, 32'h01234567, 32'h0002ABCD, 1'b0);
        chk("single_data",  fifo_data, 82'h2ABCD_01234567_DEADBEEF);
        chk("single_empty", 82'(fifo_empty), 82'(0));
        pops(1);

        // Fill to full
        for (int i = 0; i < DEPTH; i++)
            send_inst($urandom, $urandom, $urandom, 1'b0);
        chk("fill_full",  82'(fifo_full), 82'(1));
        chk("fill_count", 82'(count), 82'(8));

        // Ninth instruction stalls at the closing beat until a pop
        send_beat(32'hA5A5A5A5, 1'b0, 1'b0);
        send_beat(32'h5A5A5A5A, 1'b0, 1'b0);
        host_valid = 1'b1;
        host_data  = 32'h0001F00D;
        host_last  = 1'b1;
        chk("stall_ready0", 82'(host_ready), 82'(0));
        step(tb_acc);
        chk("stall_ready1", 82'(host_ready), 82'(0));
        read_en = 1'b1;
        step(tb_acc);
        read_en = 1'b0;
        chk("ready_after_pop", 82'(host_ready), 82'(1));
        chk("count_after_pop", 82'(count), 82'(7));
        step(tb_acc);
        chk("ninth_count", 82'(count), 82'(8));
        host_valid = 1'b0;
        host_last  = 1'b0;

        // Drain to 3, then push/pop together on each closing beat
        pops(5);
        chk("drain_to_3", 82'(count), 82'(3));
        for (int i = 0; i < 20; i++) begin
            send_inst($urandom, $urandom, $urandom, 1'b1);
            chk("pushpop_count", 82'(count), 82'(3));
        end
        pops(3);

        // Framing: host_last on beat 2
        send_beat(32'h11110000, 1'b0, 1'b0);
        send_beat(32'h22220000, 1'b1, 1'b0);
        chk("frame_last_early", 82'(frame_err), 82'(1));
        chk("frame_no_push", 82'(count), 82'(0));
        send_inst(32'hCAFEF00D, 32'h8BADF00D, 32'h00012345, 1'b0);
        chk("frame_recover", fifo_data, 82'h12345_8BADF00D_CAFEF00D);
        clear_err = 1'b1;
        step(tb_acc);
        clear_err = 1'b0;
        chk("clear_err", 82'(frame_err), 82'(0));
        // Closing beat without host_last
        send_beat(32'h1, 1'b0, 1'b0);
        send_beat(32'h2, 1'b0, 1'b0);
        send_beat(32'h3, 1'b0, 1'b0);
        chk("frame_no_last", 82'(frame_err), 82'(1));
        chk("frame_no_last_count", 82'(count), 82'(1));
        // Set beats clear in the same cycle
        clear_err = 1'b1;
        step(tb_acc);
        host_valid = 1'b1;
        host_last  = 1'b1;
        step(tb_acc);
        host_valid = 1'b0;
        host_last  = 1'b0;
        clear_err  = 1'b0;
        chk("set_beats_clear", 82'(frame_err), 82'(1));

        // Underflow: read_en held 4 cycles with 2 entries
        send_inst($urandom, $urandom, $urandom, 1'b0);
        chk("two_entries", 82'(count), 82'(2));
        pops(4);
        chk("underflow_empty", 82'(fifo_empty), 82'(1));
        chk("underflow_data", fifo_data, 82'(0));

        // Random traffic: filling phase then draining phase, pointers wrap
        for (int i = 0; i < 400; i++) begin
            host_valid = ($urandom_range(0, 3) != 0);
            host_data  = $urandom;
            host_last  = (mbeat == 2) ? ($urandom_range(0, 9) != 0)
                                      : ($urandom_range(0, 19) == 0);
            read_en    = (i < 200) ? ($urandom_range(0, 7) == 0)
                                   : ($urandom_range(0, 1) == 0);
            clear_err  = ($urandom_range(0, 15) == 0);
            step(tb_acc);
        end
        host_valid = 1'b0;
        host_last  = 1'b0;
        read_en    = 1'b0;
        clear_err  = 1'b0;
        step(tb_acc);

        // Reset mid-instruction with entries stored
        send_inst($urandom, $urandom, $urandom, 1'b0);
        send_inst($urandom, $urandom, $urandom, 1'b0);
        send_beat(32'h77777777, 1'b0, 1'b0);
        do_reset();
        chk("reset_empty", 82'(fifo_empty), 82'(1));
        chk("reset_ready", 82'(host_ready), 82'(1));
        send_inst(32'h11111111, 32'h22222222, 32'h00033333, 1'b0);
        chk("post_reset_inst", fifo_data, 82'h33333_22222222_11111111);
        chk("post_reset_count", 82'(count), 82'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
